pkg_param_streamer: RTL and testbench

- Consumer stage for the package constants in cocotb_package_pkg_1, cocotb_package_pkg_2 and the compilation-unit scope.
- Imports those constants and serializes them on request into a 32-bit valid/ready word stream, so a testbench or downstream sink can read them back through a plain stream.
- Each parameter goes out as a header word followed by its value, split into little-endian 32-bit words.
- Sits between a request source (bench driver or CSR decoder) and a stream sink.

---
 rtl/pkg_param_streamer.sv | 131 +++++++++++++
 tb/tb_pkg_param_streamer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkg_param_streamer.sv
// Streams a fixed table of package constants as header + LSW-first data words
// over a 32-bit valid/ready interface, one entry or the whole table per request.
module pkg_param_streamer #(
    parameter logic [7:0] MAGIC     = 8'hA5,
    parameter logic [2:0] ALL_INDEX = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_index,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy
);

    localparam int           five_int          = 5;
    localparam logic [7:0]   eight_logic       = 8'd8;
    localparam logic [63:0]  long_param        = 64'h0000_005A_8990_1AF1;
    localparam logic [127:0] really_long_param = {64'd0, long_param};
    localparam int           eleven_int        = 11;
    localparam int           unit_four_int     = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0] state;
    logic [2:0] entry;
    logic [1:0] cnt;
    logic       all_mode;
    logic       up;

    logic [2:0] n_words;
    logic       err;
    logic       last_w;
    logic       more;
    logic       hs;

    function automatic logic [2:0] words_of(input logic [2:0] e);
        case (e)
            3'd0, 3'd1, 3'd4, 3'd5: words_of = 3'd1;
            3'd2:                   words_of = 3'd2;
            3'd3:                   words_of = 3'd4;
            default:                words_of = 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] word_of(input logic [2:0] e,
                                            input logic [1:0] c);
        case (e)
            3'd0:    word_of = five_int;
            3'd1:    word_of = {24'd0, eight_logic};
            3'd2:    word_of = c[0] ? long_param[63:32] : long_param[31:0];
            3'd3:    word_of = really_long_param[{c, 5'd0} +: 32];
            3'd4:    word_of = eleven_int;
            3'd5:    word_of = unit_four_int;
            default: word_of = 32'd0;
        endcase
    endfunction

    assign n_words = words_of(entry);
    assign err     = (n_words == 3'd0);
    assign last_w  = ({1'b0, cnt} == n_words - 3'd1);
    assign more    = all_mode && (entry != 3'd5);

    assign out_valid = (state == HDR) || (state == DATA);
    assign hs        = out_valid && out_ready;
    assign req_ready = up && (state == IDLE);
    assign busy      = (state != IDLE) || (req_valid && req_ready);

    always_comb begin
        out_data = 32'd0;
        out_last = 1'b0;
        if (state == HDR) begin
            out_data = {MAGIC, 5'd0, entry, 5'd0, n_words, 7'd0, err};
            out_last = err;
        end else if (state == DATA) begin
            out_data = word_of(entry, cnt);
            out_last = last_w && !more;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            entry    <= 3'd0;
            cnt      <= 2'd0;
            all_mode <= 1'b0;
            up       <= 1'b0;
        end else begin
            up <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        all_mode <= (req_index == ALL_INDEX);
                        entry    <= (req_index == ALL_INDEX) ? 3'd0 : req_index;
                        cnt      <= 2'd0;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (hs) begin
                        cnt   <= 2'd0;
                        state <= err ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (hs) begin
                        if (last_w) begin
                            cnt <= 2'd0;
                            // ALL mode rolls straight into the next header
                            if (more) begin
                                entry <= entry + 3'd1;
                                state <= HDR;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkg_param_streamer.sv
// Directed bench for pkg_param_streamer: single entries, ALL dump,
// backpressure, invalid index with pending request, and mid-response reset.
module tb_pkg_param_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_index = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] got_w[$];
    bit          got_l[$];
    logic [31:0] exp[$];
    int          bubbles;
    int          stall_bad;
    bit          timeout;

    always #5 clk = ~clk;

    pkg_param_streamer dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_index(req_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy)
    );

    // Entered and left at posedge+1; holds req_valid until accepted.
    task automatic send_req(input logic [2:0] idx);
        int k;
        req_index = idx;
        req_valid = 1'b1;
        #1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        tests++;
        if (!req_ready) begin
            fails++;
            $display("FAIL req_accept idx=%0d: req_ready=%b required 1", idx, req_ready);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_at_accept idx=%0d: busy=%b required 1", idx, busy);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic collect(input int max, input bit bp);
        bit          started;
        bit          prev_stall;
        bit          done;
        logic [31:0] pd;
        logic        pl;
        got_w.delete();
        got_l.delete();
        bubbles    = 0;
        stall_bad  = 0;
        timeout    = 1'b1;
        started    = 1'b0;
        prev_stall = 1'b0;
        done       = 1'b0;
        pd         = 32'd0;
        pl         = 1'b0;
        for (int c = 0; c < max; c++) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (out_valid) begin
                if (prev_stall && (out_data !== pd || out_last !== pl))
                    stall_bad++;
                pd         = out_data;
                pl         = out_last;
                prev_stall = !out_ready;
                if (out_ready) begin
                    got_w.push_back(out_data);
                    got_l.push_back(out_last);
                    started = 1'b1;
                    if (out_last) done = 1'b1;
                end
            end else begin
                if (started) bubbles++;
                if (prev_stall) stall_bad++;
                prev_stall = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        timeout   = !done;
        out_ready = 1'b1;
    endtask

    task automatic check_resp(input string nm);
        tests++;
        if (timeout) begin
            fails++;
            $display("FAIL %s_timeout: no out_last seen, got %0d words", nm, got_w.size());
        end
        tests++;
        if (got_w.size() != exp.size()) begin
            fails++;
            $display("FAIL %s_len: got %0d words required %0d", nm, got_w.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got_w.size()) begin
                tests++;
                if (got_w[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL %s_word%0d: got %h required %h", nm, i, got_w[i], exp[i]);
                end
                tests++;
                if (got_l[i] !== (i == exp.size() - 1)) begin
                    fails++;
                    $display("FAIL %s_last%0d: got %b required %b", nm, i,
                             got_l[i], (i == exp.size() - 1));
                end
            end
        end
    endtask

    task automatic check_idle_after(input string nm);
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_after: req_ready=%b busy=%b required 1 0", nm, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (req_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 ||
            out_last !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rr=%b ov=%b od=%h ol=%b busy=%b required 0 0 0 0 0",
                     req_ready, out_valid, out_data, out_last, busy);
        end
        rst = 1'b0;
        @(posedge clk);
        #2;
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: rr=%b busy=%b ov=%b required 1 0 0",
                     req_ready, busy, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single(input string nm, input logic [2:0] idx, input bit bp);
        send_req(idx);
        collect(200, bp);
        check_resp(nm);
        if (bp) begin
            tests++;
            if (stall_bad != 0) begin
                fails++;
                $display("FAIL %s_stable: %0d unstable stall cycles required 0", nm, stall_bad);
            end
        end
        #1;
        check_idle_after(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic test_all();
        exp = '{32'hA5000100, 32'h00000005,
                32'hA5010100, 32'h00000008,
                32'hA5020200, 32'h89901AF1, 32'h0000005A,
                32'hA5030400, 32'h89901AF1, 32'h0000005A, 32'h00000000, 32'h00000000,
                32'hA5040100, 32'h0000000B,
                32'hA5050100, 32'h00000004};
        send_req(3'd7);
        collect(100, 1'b0);
        check_resp("all");
        tests++;
        if (bubbles != 0) begin
            fails++;
            $display("FAIL all_bubbles: got %0d idle cycles required 0", bubbles);
        end
        #1;
        check_idle_after("all");
        @(posedge clk);
        #1;
    endtask

    task automatic test_err_pending();
        send_req(3'd6);
        out_ready = 1'b0;
        req_valid = 1'b1;
        req_index = 3'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'hA5060001 || out_last !== 1'b1) begin
                fails++;
                $display("FAIL err_hdr_hold%0d: ov=%b od=%h ol=%b required 1 a5060001 1",
                         c, out_valid, out_data, out_last);
            end
            tests++;
            if (req_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL err_busy%0d: rr=%b busy=%b required 0 1", c, req_ready, busy);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL pend_accept: rr=%b busy=%b ov=%b required 1 1 0",
                     req_ready, busy, out_valid);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp = '{32'hA5000100, 32'h00000005};
        collect(50, 1'b0);
        check_resp("pend_idx0");
        @(posedge clk);
        #1;
    endtask

    task automatic test_rst_mid();
        send_req(3'd7);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: ov=%b ol=%b busy=%b required 0 0 0", out_valid, out_last, busy);
        end
        @(posedge clk);
        #1;
        exp = '{32'hA5050100, 32'h00000004};
        test_single("after_rst_idx5", 3'd5, 1'b0);
    endtask

    initial begin
        test_reset();
        exp = '{32'hA5000100, 32'h00000005};
        test_single("idx0", 3'd0, 1'b0);
        exp = '{32'hA5020200, 32'h89901AF1, 32'h0000005A};
        test_single("idx2", 3'd2, 1'b0);
        exp = '{32'hA5030400, 32'h89901AF1, 32'h0000005A, 32'h00000000, 32'h00000000};
        test_single("idx3", 3'd3, 1'b0);
        test_all();
        exp = '{32'hA5010100, 32'h00000008};
        test_single("idx1_bp", 3'd1, 1'b1);
        exp = '{32'hA5030400, 32'h89901AF1, 32'h0000005A, 32'h00000000, 32'h00000000};
        test_single("idx3_bp", 3'd3, 1'b1);
        exp = '{32'hA5060001};
        test_single("idx6", 3'd6, 1'b0);
        test_err_pending();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
